// File: rtl/l2cache_pkg.sv
// Shared types and helpers for the L2 cache writeback path.
// Holds the default line geometry, the buffer entry layout and the pointer-width helper.
package l2cache_pkg;

  localparam int unsigned L2_ADDR_WIDTH = 32;
  localparam int unsigned L2_LINE_BITS  = 512;

  typedef struct packed {
    logic [L2_ADDR_WIDTH-1:0] addr;
    logic [L2_LINE_BITS-1:0]  data;
  } wb_entry_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/l2cache_wbuf_cam.sv
// Parallel address compare across writeback buffer entries.
// When several valid entries match, the one written most recently (nearest the tail) wins.
module l2cache_wbuf_cam
  import l2cache_pkg::*;
#(
  parameter int unsigned addr_width = L2_ADDR_WIDTH,
  parameter int unsigned depth      = 4,
  parameter int unsigned ptr_w      = ptr_width(depth)
) (
  input  logic [addr_width-1:0] i_addrs [depth],
  input  logic [depth-1:0]      i_valid,
  input  logic [ptr_w-1:0]      i_tail,
  input  logic [addr_width-1:0] i_lkp_addr,
  output logic                  o_hit,
  output logic [ptr_w-1:0]      o_idx
);

  logic [ptr_w-1:0] w_slot;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_slot = '0;
    // Walk oldest to youngest; a later match overrides an earlier one.
    for (int k = int'(depth) - 1; k >= 0; k--) begin
      w_slot = i_tail - ptr_w'(k + 1);
      if (i_valid[w_slot] && (i_addrs[w_slot] == i_lkp_addr)) begin
        o_hit = 1'b1;
        o_idx = w_slot;
      end
    end
  end

endmodule

// File: rtl/l2cache_writeback_buffer.sv
// Dirty-victim writeback buffer: captures each victim, commits it one cycle later only if the
// dirty table says so, drains committed lines in order to memory and serves lookups until drained.
module l2cache_writeback_buffer
  import l2cache_pkg::*;
#(
  parameter int unsigned addr_width = L2_ADDR_WIDTH,
  parameter int unsigned line_bits  = L2_LINE_BITS,
  parameter int unsigned depth      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  victim_req,
  input  logic [addr_width-1:0] victim_addr,
  input  logic [line_bits-1:0]  victim_data,
  output logic                  victim_ready,
  input  logic                  victim_dirty,
  output logic                  mem_wvalid,
  output logic [addr_width-1:0] mem_waddr,
  output logic [line_bits-1:0]  mem_wdata,
  input  logic                  mem_wready,
  input  logic [addr_width-1:0] lkp_addr,
  output logic                  lkp_hit,
  output logic [line_bits-1:0]  lkp_data,
  output logic                  wb_empty
);

  localparam int unsigned PW = ptr_width(depth);
  localparam int unsigned CW = PW + 1;

  logic [addr_width-1:0] r_addr [depth];
  logic [line_bits-1:0]  r_data [depth];
  logic [depth-1:0]      r_valid;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_pend;
  logic [addr_width-1:0] r_pend_addr;
  logic [line_bits-1:0]  r_pend_data;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic [PW-1:0] w_hit_idx;

  // The pending slot is counted so a later dirty commit always finds a free entry.
  assign victim_ready = (r_count + CW'(r_pend)) < CW'(depth);
  assign w_accept     = victim_req && victim_ready;
  assign w_push       = r_pend && victim_dirty;
  assign w_pop        = mem_wvalid && mem_wready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend  <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_pend <= w_accept;
      if (w_pop) begin
        r_head          <= r_head + PW'(1);
        r_valid[r_head] <= 1'b0;
      end
      if (w_push) begin
        r_tail          <= r_tail + PW'(1);
        r_valid[r_tail] <= 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // NOTE: line storage carries no reset; r_valid and r_pend qualify every use of it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pend_addr <= victim_addr;
      r_pend_data <= victim_data;
    end
    if (w_push) begin
      r_addr[r_tail] <= r_pend_addr;
      r_data[r_tail] <= r_pend_data;
    end
  end

  l2cache_wbuf_cam #(
    .addr_width(addr_width),
    .depth     (depth),
    .ptr_w     (PW)
  ) u_cam (
    .i_addrs   (r_addr),
    .i_valid   (r_valid),
    .i_tail    (r_tail),
    .i_lkp_addr(lkp_addr),
    .o_hit     (w_hit),
    .o_idx     (w_hit_idx)
  );

  assign mem_wvalid = (r_count != '0);
  assign mem_waddr  = mem_wvalid ? r_addr[r_head] : '0;
  assign mem_wdata  = mem_wvalid ? r_data[r_head] : '0;
  assign lkp_hit    = w_hit;
  assign lkp_data   = w_hit ? r_data[w_hit_idx] : '0;
  assign wb_empty   = (r_count == '0) && !r_pend;

endmodule

// File: tb/tb_l2cache_writeback_buffer.sv
// Directed and randomized bench for l2cache_writeback_buffer against a queue-based reference model.
module tb_l2cache_writeback_buffer;
  import l2cache_pkg::*;

  localparam int AW    = 32;
  localparam int LB    = 512;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rstn;
  logic          victim_req;
  logic [AW-1:0] victim_addr;
  logic [LB-1:0] victim_data;
  logic          victim_ready;
  logic          victim_dirty;
  logic          mem_wvalid;
  logic [AW-1:0] mem_waddr;
  logic [LB-1:0] mem_wdata;
  logic          mem_wready;
  logic [AW-1:0] lkp_addr;
  logic          lkp_hit;
  logic [LB-1:0] lkp_data;
  logic          wb_empty;

  l2cache_writeback_buffer #(
    .addr_width(AW),
    .line_bits (LB),
    .depth     (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .victim_req  (victim_req),
    .victim_addr (victim_addr),
    .victim_data (victim_data),
    .victim_ready(victim_ready),
    .victim_dirty(victim_dirty),
    .mem_wvalid  (mem_wvalid),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wready  (mem_wready),
    .lkp_addr    (lkp_addr),
    .lkp_hit     (lkp_hit),
    .lkp_data    (lkp_data),
    .wb_empty    (wb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: committed lines in FIFO order plus the one line awaiting its dirty bit.
  wb_entry_t m_q[$];
  logic      m_pend;
  wb_entry_t m_pend_e;

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] v;
    for (int i = 0; i < LB / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return 32'h0000_2000 + 32'($urandom_range(0, 7)) * 32'd64;
  endfunction

  task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, then advance the model.
  task automatic step(input logic req, input logic [AW-1:0] a, input logic [LB-1:0] d,
                      input logic dirty, input logic wready, input logic [AW-1:0] lkp);
    logic          exp_ready, exp_wvalid, exp_hit, exp_empty;
    logic [AW-1:0] exp_waddr;
    logic [LB-1:0] exp_wdata, exp_ldata;
    logic          pop, push, acc;
    @(negedge clk);
    victim_req   = req;
    victim_addr  = a;
    victim_data  = d;
    victim_dirty = dirty;
    mem_wready   = wready;
    lkp_addr     = lkp;
    #1;
    exp_ready  = (m_q.size() + (m_pend ? 1 : 0)) < DEPTH;
    exp_wvalid = (m_q.size() != 0);
    exp_waddr  = '0;
    exp_wdata  = '0;
    if (exp_wvalid) begin
      exp_waddr = m_q[0].addr;
      exp_wdata = m_q[0].data;
    end
    exp_hit   = 1'b0;
    exp_ldata = '0;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (!exp_hit && (m_q[i].addr == lkp)) begin
        exp_hit   = 1'b1;
        exp_ldata = m_q[i].data;
      end
    end
    exp_empty = (m_q.size() == 0) && !m_pend;
    check("victim_ready", victim_ready, exp_ready);
    check("mem_wvalid", mem_wvalid, exp_wvalid);
    check("mem_waddr", mem_waddr, exp_waddr);
    check("mem_wdata", mem_wdata, exp_wdata);
    check("lkp_hit", lkp_hit, exp_hit);
    check("lkp_data", lkp_data, exp_ldata);
    check("wb_empty", wb_empty, exp_empty);
    pop  = exp_wvalid && wready;
    push = m_pend && dirty;
    acc  = req && exp_ready;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(m_pend_e);
    m_pend = acc;
    if (acc) begin
      m_pend_e.addr = a;
      m_pend_e.data = d;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, victim_ready, 1'b1);
    check({tag, "_wvalid"}, mem_wvalid, 1'b0);
    check({tag, "_waddr"}, mem_waddr, '0);
    check({tag, "_wdata"}, mem_wdata, '0);
    check({tag, "_hit"}, lkp_hit, 1'b0);
    check({tag, "_ldata"}, lkp_data, '0);
    check({tag, "_empty"}, wb_empty, 1'b1);
  endtask

  initial begin
    logic [LB-1:0] pat_a, pat_b, pat_c;
    pat_a = {16{32'hA5A5_1234}};
    pat_b = {16{32'hBEEF_0B0B}};
    pat_c = {16{32'hC0DE_0C0C}};
    model_reset();

    rstn         = 1'b0;
    victim_req   = 1'b0;
    victim_addr  = '0;
    victim_data  = '0;
    victim_dirty = 1'b0;
    mem_wready   = 1'b0;
    lkp_addr     = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rstn = 1'b1;

    // Single dirty victim with zero-wait memory.
    step(1'b1, 32'h1000, pat_a, 1'b0, 1'b1, 32'h1000);
    step(1'b0, '0, '0, 1'b1, 1'b1, 32'h1000);
    step(1'b0, '0, '0, 1'b0, 1'b1, 32'h1000);
    check("single_wvalid", mem_wvalid, 1'b1);
    check("single_waddr", mem_waddr, 32'h1000);
    check("single_wdata", mem_wdata, pat_a);
    step(1'b0, '0, '0, 1'b0, 1'b1, 32'h1000);
    check("single_empty", wb_empty, 1'b1);
    check("single_wvalid_low", mem_wvalid, 1'b0);

    // Clean victim is dropped.
    step(1'b1, 32'h1040, pat_b, 1'b0, 1'b1, 32'h1040);
    step(1'b0, '0, '0, 1'b0, 1'b1, 32'h1040);
    check("clean_busy", wb_empty, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 32'h1040);
    check("clean_empty", wb_empty, 1'b1);
    check("clean_no_write", mem_wvalid, 1'b0);

    // Fill under backpressure, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h4000 + 32'(i) * 32'd64, rand_line(), (i > 0), 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0);
    check("fill_not_ready", victim_ready, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, '0);
      check("fill_drain_addr", mem_waddr, 32'h4000 + 32'(i) * 32'd64);
      check("fill_ready", victim_ready, (i > 0));
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, '0);
    check("fill_empty", wb_empty, 1'b1);

    // Push and pop together at count 3 with the tail wrapping.
    step(1'b1, 32'h6000, rand_line(), 1'b0, 1'b0, '0);
    step(1'b1, 32'h6040, rand_line(), 1'b1, 1'b0, '0);
    step(1'b1, 32'h6080, rand_line(), 1'b1, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0);
    step(1'b1, 32'h60C0, rand_line(), 1'b0, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 1'b1, '0);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0);
    check("wrap_ready", victim_ready, 1'b1);
    check("wrap_head", mem_waddr, 32'h6040);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 32'h60C0);
    step(1'b0, '0, '0, 1'b0, 1'b1, '0);
    check("wrap_empty", wb_empty, 1'b1);

    // Lookup with a duplicate address: the younger copy wins.
    step(1'b1, 32'h2000, pat_b, 1'b0, 1'b0, 32'h2000);
    step(1'b1, 32'h2000, pat_c, 1'b1, 1'b0, 32'h2000);
    step(1'b0, '0, '0, 1'b1, 1'b0, 32'h2000);
    step(1'b0, '0, '0, 1'b0, 1'b0, 32'h2000);
    check("lkp_young_hit", lkp_hit, 1'b1);
    check("lkp_young_data", lkp_data, pat_c);
    step(1'b0, '0, '0, 1'b0, 1'b0, 32'h3000);
    check("lkp_miss_hit", lkp_hit, 1'b0);
    check("lkp_miss_data", lkp_data, '0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 32'h2000);

    // Randomized traffic.
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 9) < 6), rand_addr(), rand_line(), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 9) < 6), rand_addr());
    for (int n = 0; n < 8; n++) step(1'b0, '0, '0, 1'b0, 1'b1, '0);
    check("rand_drained", wb_empty, 1'b1);

    // Asynchronous reset while two entries wait and a write is offered.
    step(1'b1, 32'h5000, rand_line(), 1'b0, 1'b0, 32'h5000);
    step(1'b1, 32'h5040, rand_line(), 1'b1, 1'b0, 32'h5000);
    step(1'b0, '0, '0, 1'b1, 1'b0, 32'h5000);
    check("rst_pre_wvalid", mem_wvalid, 1'b1);
    @(negedge clk);
    victim_req   = 1'b0;
    victim_dirty = 1'b0;
    lkp_addr     = 32'h5000;
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 32'h5000);
      check("post_rst_no_write", mem_wvalid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
